shm_dma_request_queue: RTL and testbench
========================================

// Module: shm_dma_request_queue
// PURPOSE
//  Per-processor front end of the shared-memory DMA. Accepts copy requests from PROC_CNT processors over valid/ready,
//  buffers up to 2 per processor, and round-robin issues exactly one at a time to the DMA via toggle-trigger/toggle-ack.
//  Reports per-request completion or timeout to the requesting processor.
// PARAMETERS
//  PROC_CNT        2    number of processor channels (>=2)
//  SIZE            4    shared-memory address width (ptr)
//  PROCSIZE        4    processor-local address / length width
//  TIMEOUT_CYCLES  255  max cycles in WAIT_ACK before abort; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clock        in   1                       single clock, all state on posedge
//  reset_n      in   1                       asynchronous, active-low reset
//  req_valid    in   1 [0:PROC_CNT-1]        processor i offers request
//  req_ready    out  1 [0:PROC_CNT-1]        queue i has space (count<2)
//  req_action   in   1 [0:PROC_CNT-1]        0=READ (shm->proc), 1=WRITE (proc->shm)
//  req_ptr      in   SIZE [0:PROC_CNT-1]     shm word address
//  req_start    in   PROCSIZE [0:PROC_CNT-1] proc-local start address
//  req_length   in   PROCSIZE [0:PROC_CNT-1] word count; 0 is legal
//  done         out  1 [0:PROC_CNT-1]        1-cycle pulse: request completed
//  done_err     out  1 [0:PROC_CNT-1]        1-cycle pulse: request timed out (with done=0)
//  trigger      out  1 [0:PROC_CNT-1]        to DMA; toggle = new request on channel i
//  action/ptr/copy_start/copy_length  out  as req_* [0:PROC_CNT-1]  to DMA; stable from toggle until ack/timeout
//  ack          in   1 [0:PROC_CNT-1]        from DMA; toggle = request on channel i finished
//  busy         out  1                       FSM not in IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): all queues empty, req_ready=1, done=done_err=0, trigger=0, DMA fields=0, busy=0,
//   last_ack[i] sampled as 0, rr pointer=0, FSM=IDLE. Reset mid-request drops queued/in-flight requests silently.
//  Enqueue: on posedge with req_valid[i]&&req_ready[i], fields pushed to 2-entry FIFO i. req_ready is registered
//   count<2, evaluated before same-cycle pop (push into full queue never accepted even if popping).
//  FSM IDLE: search channels starting at rr for first non-empty queue; if found, pop head into DMA fields of that
//   channel, cur<=i, -> ISSUE. Pop and push on same queue same cycle both honoured.
//  ISSUE (1 cycle): trigger[cur] <= ~trigger[cur]; timer<=0 -> WAIT_ACK. Fields already stable 1 cycle before toggle.
//  WAIT_ACK: if ack[cur]!=last_ack[cur]: last_ack[cur]<=ack[cur], done[cur] pulses next cycle, -> COMPLETE.
//   Else timer+1; at timer==TIMEOUT_CYCLES: done_err[cur] pulses, last_ack[cur]<=ack[cur], -> COMPLETE.
//  COMPLETE (1 cycle): rr <= (cur+1) mod PROC_CNT (wrap), -> IDLE. Min request-to-request spacing 4 cycles.
//  Ack toggles on channels other than cur, or in any state but WAIT_ACK, update last_ack only; never produce done.
//  DMA fields of non-current channels hold last issued values; only one trigger toggles per request.
//  Length 0 is forwarded unchanged; completion still requires ack toggle.
// TESTING
//  1 proc0 WRITE ptr=4 start=2 len=3, ack[0] toggles 5 cycles after trigger -> trigger[0] toggles once, done[0] 1 pulse.
//  2 proc0 and proc1 both valid same cycle, rr=0 -> proc0 issued first, proc1 after proc0 done; rr ends at 0.
//  3 three back-to-back req_valid on proc1 -> req_ready[1] low after 2 accepted; third accepted once first issued.
//  4 no ack, TIMEOUT_CYCLES=255 -> done_err[cur] pulse 255 cycles after toggle, next queued request then issues.
//  5 spurious ack[1] toggle while serving proc0 -> no done[1], no effect on proc0 completion.
//  6 reset_n low during WAIT_ACK -> outputs immediately at reset values, queues empty, req_ready all 1.

Source files
------------

// File: rtl/shm_dma_request_queue.sv
// rtl/shm_dma_request_queue.sv - per-processor 2-deep request queues feeding a single round-robin DMA issuer
module shm_dma_request_queue #(
    parameter int PROC_CNT       = 2,
    parameter int SIZE           = 4,
    parameter int PROCSIZE       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid   [0:PROC_CNT-1],
    output logic                req_ready   [0:PROC_CNT-1],
    input  logic                req_action  [0:PROC_CNT-1],
    input  logic [SIZE-1:0]     req_ptr     [0:PROC_CNT-1],
    input  logic [PROCSIZE-1:0] req_start   [0:PROC_CNT-1],
    input  logic [PROCSIZE-1:0] req_length  [0:PROC_CNT-1],
    output logic                done        [0:PROC_CNT-1],
    output logic                done_err    [0:PROC_CNT-1],
    output logic                trigger     [0:PROC_CNT-1],
    output logic                action      [0:PROC_CNT-1],
    output logic [SIZE-1:0]     ptr         [0:PROC_CNT-1],
    output logic [PROCSIZE-1:0] copy_start  [0:PROC_CNT-1],
    output logic [PROCSIZE-1:0] copy_length [0:PROC_CNT-1],
    input  logic                ack         [0:PROC_CNT-1],
    output logic                busy
);

    localparam int CW  = $clog2(PROC_CNT);
    localparam int CW1 = CW + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW  = 1 + SIZE + 2 * PROCSIZE;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;
    localparam logic [1:0] S_COMPLETE = 2'd3;

    logic [EW-1:0]       fifo_q     [PROC_CNT][2];
    logic [EW-1:0]       fifo_d     [PROC_CNT][2];
    logic                wr_ptr_q   [PROC_CNT];
    logic                wr_ptr_d   [PROC_CNT];
    logic                rd_ptr_q   [PROC_CNT];
    logic                rd_ptr_d   [PROC_CNT];
    logic [1:0]          count_q    [PROC_CNT];
    logic [1:0]          count_d    [PROC_CNT];
    logic                trigger_q  [PROC_CNT];
    logic                trigger_d  [PROC_CNT];
    logic                last_ack_q [PROC_CNT];
    logic                last_ack_d [PROC_CNT];
    logic                done_q     [PROC_CNT];
    logic                done_d     [PROC_CNT];
    logic                done_err_q [PROC_CNT];
    logic                done_err_d [PROC_CNT];
    logic                action_q   [PROC_CNT];
    logic                action_d   [PROC_CNT];
    logic [SIZE-1:0]     ptr_q      [PROC_CNT];
    logic [SIZE-1:0]     ptr_d      [PROC_CNT];
    logic [PROCSIZE-1:0] start_q    [PROC_CNT];
    logic [PROCSIZE-1:0] start_d    [PROC_CNT];
    logic [PROCSIZE-1:0] length_q   [PROC_CNT];
    logic [PROCSIZE-1:0] length_d   [PROC_CNT];
    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cur_q, cur_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [PROC_CNT-1:0] push_vec;
    logic [PROC_CNT-1:0] pop_vec;
    logic                found;
    logic [CW-1:0]       sel;
    logic [CW:0]         idx;
    logic                wait_exit;

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        trigger_d  = trigger_q;
        last_ack_d = last_ack_q;
        action_d   = action_q;
        ptr_d      = ptr_q;
        start_d    = start_q;
        length_d   = length_q;
        state_d    = state_q;
        cur_d      = cur_q;
        rr_d       = rr_q;
        timer_d    = timer_q;
        push_vec   = '0;
        pop_vec    = '0;
        found      = 1'b0;
        sel        = '0;
        idx        = '0;
        wait_exit  = 1'b0;
        for (int i = 0; i < PROC_CNT; i++) begin
            done_d[i]     = 1'b0;
            done_err_d[i] = 1'b0;
        end

        // First non-empty queue at or after the round-robin pointer, wrapping.
        for (int off = 0; off < PROC_CNT; off++) begin
            idx = {1'b0, rr_q} + CW1'(off);
            if (idx >= CW1'(PROC_CNT)) begin
                idx = idx - CW1'(PROC_CNT);
            end
            if (!found && count_q[idx[CW-1:0]] != 2'd0) begin
                found = 1'b1;
                sel   = idx[CW-1:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    pop_vec[sel] = 1'b1;
                    {action_d[sel], ptr_d[sel], start_d[sel], length_d[sel]} = fifo_q[sel][rd_ptr_q[sel]];
                    cur_d   = sel;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                trigger_d[cur_q] = ~trigger_q[cur_q];
                timer_d          = '0;
                state_d          = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack[cur_q] != last_ack_q[cur_q]) begin
                    done_d[cur_q] = 1'b1;
                    wait_exit     = 1'b1;
                    state_d       = S_COMPLETE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES)) begin
                    done_err_d[cur_q] = 1'b1;
                    wait_exit         = 1'b1;
                    state_d           = S_COMPLETE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                rr_d    = (cur_q == CW'(PROC_CNT - 1)) ? '0 : cur_q + CW'(1);
                state_d = S_IDLE;
            end
        endcase

        // Only the channel being waited on holds its ack reference; all others just track.
        for (int i = 0; i < PROC_CNT; i++) begin
            if (state_q != S_WAIT_ACK || CW'(i) != cur_q || wait_exit) begin
                last_ack_d[i] = ack[i];
            end
        end

        for (int i = 0; i < PROC_CNT; i++) begin
            push_vec[i] = req_valid[i] && (count_q[i] != 2'd2);
            if (push_vec[i]) begin
                fifo_d[i][wr_ptr_q[i]] = {req_action[i], req_ptr[i], req_start[i], req_length[i]};
                wr_ptr_d[i]            = ~wr_ptr_q[i];
            end
            if (pop_vec[i]) begin
                rd_ptr_d[i] = ~rd_ptr_q[i];
            end
            count_d[i] = count_q[i] + {1'b0, push_vec[i]} - {1'b0, pop_vec[i]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PROC_CNT; i++) begin
                fifo_q[i][0]  <= '0;
                fifo_q[i][1]  <= '0;
                wr_ptr_q[i]   <= 1'b0;
                rd_ptr_q[i]   <= 1'b0;
                count_q[i]    <= 2'd0;
                trigger_q[i]  <= 1'b0;
                last_ack_q[i] <= 1'b0;
                done_q[i]     <= 1'b0;
                done_err_q[i] <= 1'b0;
                action_q[i]   <= 1'b0;
                ptr_q[i]      <= '0;
                start_q[i]    <= '0;
                length_q[i]   <= '0;
            end
            state_q <= S_IDLE;
            cur_q   <= '0;
            rr_q    <= '0;
            timer_q <= '0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            trigger_q  <= trigger_d;
            last_ack_q <= last_ack_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
            action_q   <= action_d;
            ptr_q      <= ptr_d;
            start_q    <= start_d;
            length_q   <= length_d;
            state_q    <= state_d;
            cur_q      <= cur_d;
            rr_q       <= rr_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        for (int i = 0; i < PROC_CNT; i++) begin
            req_ready[i]   = (count_q[i] != 2'd2);
            done[i]        = done_q[i];
            done_err[i]    = done_err_q[i];
            trigger[i]     = trigger_q[i];
            action[i]      = action_q[i];
            ptr[i]         = ptr_q[i];
            copy_start[i]  = start_q[i];
            copy_length[i] = length_q[i];
        end
        busy = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_shm_dma_request_queue.sv
// tb/tb_shm_dma_request_queue.sv - directed vector bench for shm_dma_request_queue
module tb_shm_dma_request_queue;

    localparam int TMO = 255;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid   [0:1];
    logic       req_ready   [0:1];
    logic       req_action  [0:1];
    logic [3:0] req_ptr     [0:1];
    logic [3:0] req_start   [0:1];
    logic [3:0] req_length  [0:1];
    logic       done        [0:1];
    logic       done_err    [0:1];
    logic       trigger     [0:1];
    logic       action      [0:1];
    logic [3:0] ptr         [0:1];
    logic [3:0] copy_start  [0:1];
    logic [3:0] copy_length [0:1];
    logic       ack         [0:1];
    logic       busy;

    shm_dma_request_queue #(
        .PROC_CNT(2), .SIZE(4), .PROCSIZE(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_action(req_action),
        .req_ptr(req_ptr), .req_start(req_start), .req_length(req_length),
        .done(done), .done_err(done_err), .trigger(trigger), .action(action),
        .ptr(ptr), .copy_start(copy_start), .copy_length(copy_length),
        .ack(ack), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic [1:0]  valid;
        logic [1:0]  act;
        logic [3:0]  p0, p1, s0, s1, l0, l1;
        logic [1:0]  ackv;
        logic [20:0] exp_o;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // {ready[1:0], busy, trigger[1:0], done[1:0], done_err[1:0], ptr0, ptr1, copy_length0}
    function automatic logic [20:0] ex(input logic [1:0] rdy, input logic bsy, input logic [1:0] trg,
                                       input logic [1:0] dn, input logic [1:0] er,
                                       input logic [3:0] ep0, input logic [3:0] ep1, input logic [3:0] el0);
        return {rdy, bsy, trg, dn, er, ep0, ep1, el0};
    endfunction

    function automatic logic [20:0] snap();
        return {req_ready[1], req_ready[0], busy, trigger[1], trigger[0], done[1], done[0],
                done_err[1], done_err[0], ptr[0], ptr[1], copy_length[0]};
    endfunction

    task automatic add(input logic r, input logic [1:0] v, input logic [1:0] a,
                       input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] l0, input logic [3:0] l1, input logic [1:0] k, input logic [20:0] e);
        vec_t t;
        t.rst_n = r; t.valid = v; t.act = a; t.p0 = p0; t.p1 = p1; t.s0 = s0; t.s1 = s1;
        t.l0 = l0; t.l1 = l1; t.ackv = k; t.exp_o = e;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic [1:0] k, input logic [20:0] e);
        add(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, k, e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic wait_issue(input int ch, input logic [3:0] want_ptr, input string name);
        logic prev;
        bit   seen;
        prev = trigger[ch];
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (trigger[ch] != prev) seen = 1;
        end
        chk({name, "_trig"}, 32'(seen), 32'd1);
        chk({name, "_ptr"}, 32'(ptr[ch]), 32'(want_ptr));
    endtask

    task automatic serve(input int ch, input string name);
        bit seen;
        seen = 0;
        ack[ch] = ~ack[ch];
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (done[ch]) seen = 1;
        end
        chk({name, "_done"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int  n;
        bit  saw_done;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_action[i] = 0; req_ptr[i] = 0;
            req_start[i] = 0; req_length[i] = 0; ack[i] = 0;
        end

        // Test 1: single WRITE on proc0, ack 5 cycles after trigger
        add(1, 2'b01, 2'b01, 4'd4, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0, 2'b00, ex(2'b11, 0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0));
        idle(2'b00, ex(2'b11, 1, 2'b00, 2'b00, 2'b00, 4'd4, 4'd0, 4'd3));
        for (int i = 0; i < 5; i++) idle(2'b00, ex(2'b11, 1, 2'b01, 2'b00, 2'b00, 4'd4, 4'd0, 4'd3));
        idle(2'b01, ex(2'b11, 1, 2'b01, 2'b01, 2'b00, 4'd4, 4'd0, 4'd3));
        idle(2'b01, ex(2'b11, 0, 2'b01, 2'b00, 2'b00, 4'd4, 4'd0, 4'd3));
        idle(2'b01, ex(2'b11, 0, 2'b01, 2'b00, 2'b00, 4'd4, 4'd0, 4'd3));
        // Test 2 + 5: simultaneous requests from rr=0, zero length, spurious ack on idle channel
        add(0, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, ex(2'b11, 0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0));
        add(1, 2'b11, 2'b10, 4'd1, 4'd9, 4'd5, 4'd3, 4'd0, 4'd7, 2'b00, ex(2'b11, 0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0));
        idle(2'b00, ex(2'b11, 1, 2'b00, 2'b00, 2'b00, 4'd1, 4'd0, 4'd0));
        idle(2'b00, ex(2'b11, 1, 2'b01, 2'b00, 2'b00, 4'd1, 4'd0, 4'd0));
        idle(2'b01, ex(2'b11, 1, 2'b01, 2'b01, 2'b00, 4'd1, 4'd0, 4'd0));
        idle(2'b01, ex(2'b11, 0, 2'b01, 2'b00, 2'b00, 4'd1, 4'd0, 4'd0));
        idle(2'b01, ex(2'b11, 1, 2'b01, 2'b00, 2'b00, 4'd1, 4'd9, 4'd0));
        idle(2'b01, ex(2'b11, 1, 2'b11, 2'b00, 2'b00, 4'd1, 4'd9, 4'd0));
        idle(2'b11, ex(2'b11, 1, 2'b11, 2'b10, 2'b00, 4'd1, 4'd9, 4'd0));
        idle(2'b11, ex(2'b11, 0, 2'b11, 2'b00, 2'b00, 4'd1, 4'd9, 4'd0));
        add(1, 2'b11, 2'b00, 4'd6, 4'd8, 4'd1, 4'd4, 4'd2, 4'd5, 2'b11, ex(2'b11, 0, 2'b11, 2'b00, 2'b00, 4'd1, 4'd9, 4'd0));
        idle(2'b11, ex(2'b11, 1, 2'b11, 2'b00, 2'b00, 4'd6, 4'd9, 4'd2));
        idle(2'b11, ex(2'b11, 1, 2'b10, 2'b00, 2'b00, 4'd6, 4'd9, 4'd2));
        idle(2'b01, ex(2'b11, 1, 2'b10, 2'b00, 2'b00, 4'd6, 4'd9, 4'd2));
        idle(2'b00, ex(2'b11, 1, 2'b10, 2'b01, 2'b00, 4'd6, 4'd9, 4'd2));
        idle(2'b00, ex(2'b11, 0, 2'b10, 2'b00, 2'b00, 4'd6, 4'd9, 4'd2));
        idle(2'b00, ex(2'b11, 1, 2'b10, 2'b00, 2'b00, 4'd6, 4'd8, 4'd2));
        idle(2'b00, ex(2'b11, 1, 2'b00, 2'b00, 2'b00, 4'd6, 4'd8, 4'd2));
        idle(2'b00, ex(2'b11, 1, 2'b00, 2'b00, 2'b00, 4'd6, 4'd8, 4'd2));
        idle(2'b10, ex(2'b11, 1, 2'b00, 2'b10, 2'b00, 4'd6, 4'd8, 4'd2));
        idle(2'b10, ex(2'b11, 0, 2'b00, 2'b00, 2'b00, 4'd6, 4'd8, 4'd2));

        // Reset state
        step();
        chk("reset_state", 32'(snap()), 32'(ex(2'b11, 0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0)));
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            reset_n = vecs[k].rst_n;
            for (int i = 0; i < 2; i++) begin
                req_valid[i]  = vecs[k].valid[i];
                req_action[i] = vecs[k].act[i];
                ack[i]        = vecs[k].ackv[i];
            end
            req_ptr[0] = vecs[k].p0; req_ptr[1] = vecs[k].p1;
            req_start[0] = vecs[k].s0; req_start[1] = vecs[k].s1;
            req_length[0] = vecs[k].l0; req_length[1] = vecs[k].l1;
            step();
            chk($sformatf("vec%0d", k), 32'(snap()), 32'(vecs[k].exp_o));
        end
        reset_n = 1'b1;

        // Test 3: proc1 fills while the DMA is busy with proc0
        req_valid[0] = 1; req_ptr[0] = 4'd2; step();
        req_valid[0] = 0;
        req_valid[1] = 1; req_ptr[1] = 4'd3; step();
        req_ptr[1] = 4'd5; step();
        chk("t3_full", 32'(req_ready[1]), 32'd0);
        req_ptr[1] = 4'd7; step();
        chk("t3_held", 32'(req_ready[1]), 32'd0);
        ack[0] = ~ack[0]; step();
        chk("t3_done0", 32'(done[0]), 32'd1);
        step();
        step();
        chk("t3_pop_x", 32'({req_ready[1], ptr[1]}), 32'({1'b1, 4'd3}));
        step();
        chk("t3_z_taken", 32'(req_ready[1]), 32'd0);
        req_valid[1] = 0;
        serve(1, "t3_x");
        wait_issue(1, 4'd5, "t3_y");
        serve(1, "t3_y");
        wait_issue(1, 4'd7, "t3_z");
        serve(1, "t3_z");

        // Test 4: timeout on proc0, queued proc1 issues afterwards
        req_valid[0] = 1; req_ptr[0] = 4'hA;
        req_valid[1] = 1; req_ptr[1] = 4'hB;
        step();
        req_valid[0] = 0; req_valid[1] = 0;
        wait_issue(0, 4'hA, "t4_a");
        n = 0; saw_done = 0;
        while (n < TMO + 20 && !done_err[0]) begin
            step();
            n++;
            if (done[0]) saw_done = 1;
        end
        chk("t4_err_window", 32'(n >= TMO && n <= TMO + 2), 32'd1);
        chk("t4_no_done", 32'(saw_done), 32'd0);
        step();
        chk("t4_err_pulse", 32'(done_err[0]), 32'd0);
        wait_issue(1, 4'hB, "t4_b");
        serve(1, "t4_b");

        // Test 6: async reset in WAIT_ACK with work still queued
        req_valid[0] = 1; req_ptr[0] = 4'hC;
        req_valid[1] = 1; req_ptr[1] = 4'hD;
        step();
        req_ptr[0] = 4'hE; step();
        req_valid[0] = 0; req_valid[1] = 0;
        step(); step();
        chk("t6_busy_pre", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async", 32'(snap()), 32'(ex(2'b11, 0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0)));
        ack[0] = 0; ack[1] = 0;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("t6_empty", 32'({busy, req_ready[1], req_ready[0]}), 32'b011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
